counter_driver: RTL and testbench
=================================

Name: counter_driver

Overview:
- Command-side initiator for the 16-bit up/down counter with load.
- Accepts a command {start, target, direction} over a valid/ready handshake.
- Drives the counter's control pins (data_in, ld_cnt, updn_cnt, count_enb) to load start, then counts to target. It checks the counter's data_out every cycle against an internal shadow model.
- Reports completion with a one-cycle done pulse plus a pass/fail verdict. Used as the on-chip sequencer for the counter and as a reusable stimulus engine in counter benches.

Parameters:
WIDTH, 16, counter data width; all values and arithmetic are modulo 2^WIDTH

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_start  input  WIDTH  value to load into the counter
cmd_target  input  WIDTH  value the counter must reach
cmd_dir  input  1  1 = count up, 0 = count down
data_in  output  WIDTH  to counter load data
ld_cnt  output  1  to counter, active-low load (0 = load data_in)
updn_cnt  output  1  to counter, 1 = up, 0 = down
count_enb  output  1  to counter count enable (effective only when ld_cnt=1)
data_out  input  WIDTH  from counter, registered count value
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
pass  output  1  valid with done; 1 = no mismatch during the command
err_value  output  WIDTH  data_out captured at the first mismatch of the current command

Behaviour:
- Counter contract being driven:
  - ld_cnt=0 loads data_in.
  - ld_cnt=1 & count_enb=1 steps ±1 (wraps modulo 2^WIDTH).
  - ld_cnt=1 & count_enb=0 holds.
  - data_out updates at the edge after the controls are sampled.
- Reset (rst high at an edge): after that edge,
  - state=IDLE
  - ld_cnt=1, count_enb=0, updn_cnt=0, data_in=0
  - busy=0, done=0, pass=0, err_value=0
  - cmd_ready=0 while rst=1.
- All outputs are registered except cmd_ready; cmd_ready = (state==IDLE) & !rst.
- Handshake:
  - A command is accepted on an edge with cmd_valid & cmd_ready. Fields are captured at that edge.
  - cmd_valid is ignored while busy; the command is neither queued nor dropped, so the source must hold it.
- Step count at accept: N = (target - start) mod 2^WIDTH if dir=1; N = (start - target) mod 2^WIDTH if dir=0. Range 0..2^WIDTH-1.
- FSM, with accept in cycle 0:
  - IDLE: cmd_ready=1, busy=0. On accept -> LOAD.
  - LOAD (cycle 1): ld_cnt=0, data_in=start, count_enb=0, busy=1. Clear err flag; exp := start. -> SETTLE.
  - SETTLE (cycle 2): ld_cnt=1, count_enb=0. Compare data_out vs exp. -> COUNT if N>0, else -> CHECK.
  - COUNT (cycles 3..2+N): count_enb=1, updn_cnt=dir. Each cycle compare data_out vs exp, then exp := exp±1 and remaining := remaining-1. Leave COUNT after exactly N cycles -> CHECK.
  - CHECK (cycle 3+N): count_enb=0. Compare data_out vs exp (= target). -> DONE.
  - DONE (cycle 4+N): done=1, pass = !err, busy=1. -> IDLE.
- Mismatch:
  - A compare failure sets the sticky err flag for the current command.
  - The first failure latches data_out into err_value; later failures do not overwrite it.
  - The sequence is never aborted by a mismatch; it always completes to DONE.
- err_value holds until the next LOAD clears it to 0.
- Latency: done is asserted exactly 4+N cycles after accept. The earliest next accept is the cycle after DONE.
- Wrap-around is implicit in modulo arithmetic, e.g. up from 0xFFFF gives 0x0000.
- Reset mid-operation: abort and return to IDLE. No done pulse. Control outputs take reset values after the reset edge. The counter value is left as-is.

Test Plan:
- start=0x0010, target=0x0014, dir=1 -> ld_cnt=0 with data_in=0x0010 in cycle 1; count_enb=1 in cycles 3-6; data_out=0x0014 in cycle 7; done=1, pass=1 in cycle 8.
- start=0xFFFE, target=0x0001, dir=1 -> N=3; data_out 0xFFFE,0xFFFF,0x0000,0x0001; done in cycle 7, pass=1.
- start=0x0001, target=0xFFFF, dir=0 -> N=2; data_out 0x0001,0x0000,0xFFFF; done in cycle 6, pass=1.
- start=target=0x1234 -> count_enb never asserted; done in cycle 4, pass=1; cmd_valid held during busy is not accepted until IDLE.
- Faulty counter model that ignores count_enb, start=0x0005, target=0x0007, dir=1 -> first mismatch in cycle 4 (exp 0x0006); err_value=0x0005; done in cycle 6 with pass=0.
- start=0x0000, target=0x0100, dir=1; rst=1 in cycle 10 -> after that edge count_enb=0, ld_cnt=1, busy=0, no done pulse; cmd_ready=1 the cycle after rst drops; a new command is accepted and passes.

Source files
------------

// File: rtl/counter_driver.sv
// Command sequencer for a 16-bit up/down counter: loads a start value, counts to
// a target, and checks the counter's data_out every cycle against a shadow model.
module counter_driver #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  input  logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] err_value
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_COUNT  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] target;
    logic             dir;
  } cmd_t;

  logic [2:0]       state;
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] remaining;
  logic             dir_q;
  logic             err;
  logic             accept;
  logic             cmp_en;
  logic             mismatch;
  cmd_t             cmd;

  assign cmd       = '{start: cmd_start, target: cmd_target, dir: cmd_dir};
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign cmp_en    = (state == S_SETTLE) || (state == S_COUNT) || (state == S_CHECK);
  assign mismatch  = (data_out != exp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ld_cnt    <= 1'b1;
      count_enb <= 1'b0;
      updn_cnt  <= 1'b0;
      data_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_value <= '0;
      exp_val   <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Sticky error; only the first mismatch of a command is captured.
      if (cmp_en && mismatch) begin
        err <= 1'b1;
        if (!err) err_value <= data_out;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_LOAD;
            ld_cnt    <= 1'b0;
            data_in   <= cmd.start;
            exp_val   <= cmd.start;
            remaining <= cmd.dir ? (cmd.target - cmd.start) : (cmd.start - cmd.target);
            dir_q     <= cmd.dir;
            err       <= 1'b0;
            err_value <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= S_SETTLE;
          ld_cnt <= 1'b1;
        end
        S_SETTLE: begin
          if (remaining != '0) begin
            state     <= S_COUNT;
            count_enb <= 1'b1;
            updn_cnt  <= dir_q;
          end else begin
            state <= S_CHECK;
          end
        end
        S_COUNT: begin
          exp_val   <= dir_q ? (exp_val + ONE) : (exp_val - ONE);
          remaining <= remaining - ONE;
          // Drop enable one cycle early: the counter steps on the edge it samples it.
          if (remaining == ONE) begin
            count_enb <= 1'b0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_DONE;
          done  <= 1'b1;
          pass  <= !(err || mismatch);
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver with a behavioural counter that can be made
// to ignore its count enable (never steps) to provoke mismatches.
module tb_counter_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_start, cmd_target;
  logic        cmd_dir;
  logic [15:0] data_in;
  logic        ld_cnt, updn_cnt, count_enb;
  logic [15:0] data_out;
  logic        busy, done, pass;
  logic [15:0] err_value;

  logic [15:0] cnt;
  logic        stuck;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  counter_driver #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .data_out(data_out),
    .busy(busy), .done(done), .pass(pass), .err_value(err_value)
  );

  always_ff @(posedge clk) begin
    if (!ld_cnt) cnt <= data_in;
    else if (count_enb && !stuck) cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
  end
  assign data_out = cnt;

  typedef struct {
    logic [15:0] start;
    logic [15:0] target;
    logic        dir;
    int          n;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller must be in an idle cycle (cycle 0); runs through the done cycle and one more.
  task automatic run_cmd(input logic [15:0] s, input logic [15:0] t, input logic d,
                         input int n, input logic exp_pass, input logic [15:0] exp_err);
    chk("ready_at_issue", cmd_ready, 1);
    cmd_start = s; cmd_target = t; cmd_dir = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= n + 4; cyc++) begin
      if (cyc == 1) begin
        chk("load_ld_cnt", ld_cnt, 0);
        chk("load_data_in", data_in, s);
        chk("load_busy", busy, 1);
      end else begin
        chk("ld_cnt_high", ld_cnt, 1);
      end
      if (cyc == 2) chk("err_cleared", err_value, 0);
      chk("count_enb", count_enb, (cyc >= 3 && cyc <= n + 2) ? 1 : 0);
      if (cyc >= 3 && cyc <= n + 2) chk("updn_cnt", updn_cnt, d);
      chk("done_timing", done, (cyc == n + 4) ? 1 : 0);
      if (cyc == n + 3 && !stuck) chk("final_data_out", data_out, t);
      if (cyc == n + 4) begin
        chk("pass", pass, exp_pass);
        chk("err_value", err_value, exp_err);
        chk("busy_in_done", busy, 1);
      end
      tick();
    end
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0010, 16'h0014, 1'b1, 4};
    vecs[1] = '{16'hFFFE, 16'h0001, 1'b1, 3};
    vecs[2] = '{16'h0001, 16'hFFFF, 1'b0, 2};
    vecs[3] = '{16'h1234, 16'h1234, 1'b1, 0};
    vecs[4] = '{16'h8000, 16'h7FFD, 1'b0, 3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0; cmd_dir = 1'b0; stuck = 1'b0;
    tick(); tick();
    chk("rst_ld_cnt", ld_cnt, 1);
    chk("rst_count_enb", count_enb, 0);
    chk("rst_updn", updn_cnt, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_value", err_value, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 5; i++)
      run_cmd(vecs[i].start, vecs[i].target, vecs[i].dir, vecs[i].n, 1'b1, 16'h0000);

    // cmd_valid held through a zero-step command: second accept only once idle.
    cmd_start = 16'h1234; cmd_target = 16'h1234; cmd_dir = 1'b1; cmd_valid = 1'b1;
    tick();
    chk("hold_c1_ld", ld_cnt, 0);
    chk("hold_c1_ready", cmd_ready, 0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("hold_ready_busy", cmd_ready, 0);
      chk("hold_no_reload", ld_cnt, 1);
      chk("hold_no_count", count_enb, 0);
    end
    chk("hold_done", done, 1);
    chk("hold_pass", pass, 1);
    tick();
    chk("hold_c5_ready", cmd_ready, 1);
    chk("hold_c5_busy", busy, 0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_reaccept_ld", ld_cnt, 0);
    chk("hold_reaccept_busy", busy, 1);
    for (int c = 7; c <= 9; c++) begin
      tick();
      chk("hold2_count_enb", count_enb, 0);
      chk("hold2_done", done, (c == 9) ? 1 : 0);
    end
    tick();
    chk("hold2_ready", cmd_ready, 1);

    // Counter ignores count_enb: first mismatch in cycle 4 captures 0x0005.
    stuck = 1'b1;
    run_cmd(16'h0005, 16'h0007, 1'b1, 2, 1'b0, 16'h0005);
    stuck = 1'b0;
    run_cmd(16'h00FF, 16'h0101, 1'b1, 2, 1'b1, 16'h0000);

    // Reset in the middle of a long count.
    cmd_start = 16'h0000; cmd_target = 16'h0100; cmd_dir = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (9) tick();
    chk("midrst_counting", count_enb, 1);
    rst = 1'b1;
    tick();
    chk("midrst_count_enb", count_enb, 0);
    chk("midrst_ld_cnt", ld_cnt, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready_in_rst", cmd_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", cmd_ready, 1);
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_done", done, 0);
      tick();
    end
    run_cmd(16'h0100, 16'h00FE, 1'b0, 2, 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
